led_pattern_ctrl: RTL and testbench

Sequencer for the board LED bank. It drives N_LED LEDs with one of four animated patterns, stepped by an internal prescaled tick. A debounced push-button cycles through the patterns. It replaces free-running single-LED blinkers at the top level: CLOCK_50 in, KEY in, LEDR out.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_pattern_ctrl_key_debounce.sv | 47 ++++
 rtl/led_pattern_ctrl.sv | 147 ++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes, bounce direction
// and the ms-to-cycles helper used to size the debounce window.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int cyc_per_ms(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, counter debounce and a
// one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter int DB_CYC = 5
) (
  input  logic clk,
  input  logic nRst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          s1_q, s2_q, lvl_q, press_q;
  logic [CW-1:0] cnt_q;
  logic          done;

  assign done = (cnt_q == CW'(DB_CYC - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_n;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (done) begin
        cnt_q   <= '0;
        lvl_q   <= s2_q;
        press_q <= ~s2_q;  // only a new low level is a press
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = lvl_q;
  assign press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: prescaled step tick, button-cycled mode FSM and four
// animated patterns. Optional LED_PWM_EN adds a 4-bit brightness PWM.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_HZ = 4,
  parameter int N_LED   = 10,
  parameter int DB_MS   = 20
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             key_n,
  input  logic             run,
`ifdef LED_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode,
  output logic             step_tick
);

  localparam int STEP_CYC = CLK_HZ / STEP_HZ;
  localparam int DB_CYC   = cyc_per_ms(CLK_HZ, DB_MS);
  localparam int PW       = $clog2(STEP_CYC);
  localparam int POS_W    = $clog2(N_LED + 1);

  logic             press, key_lvl, adv;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             phase_q, phase_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [N_LED-1:0] pat_d;

  key_debounce #(.DB_CYC(DB_CYC)) u_key (
    .clk   (clk),
    .nRst  (nRst),
    .key_n (key_n),
    .level (key_lvl),
    .press (press)
  );

  // debounced level is already low for the whole press pulse
  assign adv       = press & ~key_lvl;
  assign step_tick = run & (pre_q == PW'(STEP_CYC - 1));

  function automatic logic [N_LED-1:0] pattern(input mode_e m,
                                               input logic [POS_W-1:0] p,
                                               input logic ph);
    logic [N_LED-1:0] r;
    r = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (m)
        MODE_BLINK: r[i] = ph;
        MODE_FILL:  r[i] = (i < int'(p));
        default:    r[i] = (i == int'(p));
      endcase
    end
    return r;
  endfunction

  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    pre_d   = pre_q;
    if (run) pre_d = step_tick ? '0 : pre_q + 1'b1;
    if (adv) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      pos_d   = '0;
      dir_d   = DIR_UP;
      phase_d = 1'b0;
      pre_d   = '0;
    end else if (step_tick) begin
      case (mode_q)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_CHASE: pos_d = (pos_q == POS_W'(N_LED - 1)) ? '0 : pos_q + 1'b1;
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_W'(N_LED - 1)) begin
              pos_d = pos_q - 1'b1;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        default: pos_d = (pos_q == POS_W'(N_LED)) ? '0 : pos_q + 1'b1;
      endcase
    end
    pat_d = pattern(mode_d, pos_d, phase_d);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mode_q  <= MODE_BLINK;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      phase_q <= 1'b0;
      pre_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      pre_q   <= pre_d;
    end
  end

  assign mode = mode_q;

`ifdef LED_PWM_EN
  logic [3:0]       pwm_q;
  logic [N_LED-1:0] led_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      pwm_q <= (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
      led_q <= pat_d & {N_LED{pwm_q < bright}};
    end
  end

  assign led = led_q;
`else
  logic [N_LED-1:0] pat_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) pat_q <= '0;
    else       pat_q <= pat_d;
  end

  assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl at CLK_HZ=1000, STEP_HZ=100, N_LED=4,
// DB_MS=5 (10-cycle step, 5-cycle debounce). Covers LED_PWM_EN when defined.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       nRst, key_n, run;
  logic [3:0] led;
  logic [1:0] mode;
  logic       step_tick;
`ifdef LED_PWM_EN
  logic [3:0] bright;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.CLK_HZ(1000), .STEP_HZ(100), .N_LED(4), .DB_MS(5)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .key_n     (key_n),
    .run       (run),
`ifdef LED_PWM_EN
    .bright    (bright),
`endif
    .led       (led),
    .mode      (mode),
    .step_tick (step_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait for the next step pulse (bounded), then check led one cycle later
  task automatic next_step(input string tag, input logic [3:0] exp_led);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!step_tick && n < 40);
    chk({tag, "_gap"}, 32'(n), 32'd9);
    @(negedge clk);
    chk(tag, 32'(led), 32'(exp_led));
  endtask

  // clean press: mode changes 8 cycles after the key edge
  task automatic press_key(input string tag, input logic [1:0] m0,
                           input logic [1:0] m1, input logic [3:0] l1);
    key_n = 1'b0;
    repeat (7) @(negedge clk);
    chk({tag, "_pre"}, 32'(mode), 32'(m0));
    @(negedge clk);
    chk({tag, "_mode"}, 32'(mode), 32'(m1));
    chk({tag, "_led"}, 32'(led), 32'(l1));
    key_n = 1'b1;
  endtask

  initial begin
    int ticks;
    int hi;
    nRst  = 1'b1;
    key_n = 1'b1;
    run   = 1'b1;
`ifdef LED_PWM_EN
    bright = 4'd15;
`endif
    #1 nRst = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_tick", 32'(step_tick), 32'h0);
    #10 nRst = 1'b1;

    // BLINK
    next_step("blink_on", 4'hF);
    next_step("blink_off", 4'h0);
    next_step("blink_on2", 4'hF);

    // CHASE via a clean press; release after the first chase step
    press_key("p_chase", 2'd0, 2'd1, 4'b0001);
    key_n = 1'b0;
    next_step("chase1", 4'b0010);
    key_n = 1'b1;
    next_step("chase2", 4'b0100);
    next_step("chase3", 4'b1000);
    next_step("chase0", 4'b0001);
    chk("chase_mode", 32'(mode), 32'd1);

    // 3-cycle glitches never pass the 5-cycle window
    for (int g = 0; g < 4; g++) begin
      key_n = 1'b0;
      repeat (3) @(negedge clk);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    chk("glitch_mode", 32'(mode), 32'd1);

    // a 6-cycle hold is one press
    key_n = 1'b0;
    repeat (6) @(negedge clk);
    key_n = 1'b1;
    @(negedge clk);
    chk("hold6_pre", 32'(mode), 32'd1);
    @(negedge clk);
    chk("hold6_mode", 32'(mode), 32'd2);
    chk("bounce0", 32'(led), 32'b0001);

    // BOUNCE
    next_step("bounce1", 4'b0010);
    next_step("bounce2", 4'b0100);
    next_step("bounce3", 4'b1000);
    next_step("bounce4", 4'b0100);
    next_step("bounce5", 4'b0010);
    next_step("bounce6", 4'b0001);
    next_step("bounce7", 4'b0010);
    chk("bounce_mode", 32'(mode), 32'd2);

    // FILL
    press_key("p_fill", 2'd2, 2'd3, 4'b0000);
    next_step("fill1", 4'b0001);
    next_step("fill2", 4'b0011);
    next_step("fill3", 4'b0111);
    next_step("fill4", 4'b1111);
    next_step("fill0", 4'b0000);

    // press lands on the tick cycle: press wins, prescaler restarts
    repeat (2) @(negedge clk);
    key_n = 1'b0;
    repeat (7) @(negedge clk);
    chk("coinc_tick", 32'(step_tick), 32'd1);
    chk("coinc_pre", 32'(mode), 32'd3);
    @(negedge clk);
    chk("coinc_mode", 32'(mode), 32'd0);
    chk("coinc_led", 32'(led), 32'h0);
    key_n = 1'b1;
    next_step("coinc_next", 4'hF);

    // freeze
    run = 1'b0;
    ticks = 0;
    repeat (30) begin
      @(negedge clk);
      if (step_tick) ticks++;
    end
    chk("frz_ticks", 32'(ticks), 32'd0);
    chk("frz_led", 32'(led), 32'hF);
    run = 1'b1;
    next_step("resume", 4'h0);

    // async reset mid-CHASE at pos=2
    press_key("p_chase2", 2'd0, 2'd1, 4'b0001);
    next_step("chase_b1", 4'b0010);
    next_step("chase_b2", 4'b0100);
    #2 nRst = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_mode", 32'(mode), 32'h0);
    chk("arst_tick", 32'(step_tick), 32'h0);
    #1 nRst = 1'b1;
    next_step("arst_blink", 4'hF);
    chk("arst_mode2", 32'(mode), 32'h0);

`ifdef LED_PWM_EN
    run = 1'b0;
    bright = 4'd5;
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    chk("pwm_duty", 32'(hi), 32'd5);
    bright = 4'd0;
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      if (led != 4'h0) hi++;
    end
    chk("pwm_dark", 32'(hi), 32'd0);
`else
    hi = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
